// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 search pipeline (md5core and md5_match).
// Provides digest/message widths, block padding constants, the search state
// encoding, the digest payload struct and a saturating counter helper.
package md5_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned DIGEST_W = 4 * WORD_W;
  localparam int unsigned MSG_BITS = 152;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned BLOCK_W  = 512;

  // Padding byte following the message and the message length in bits (19 bytes)
  localparam logic [7:0]  PAD_BYTE = 8'h80;
  localparam logic [15:0] MSG_LEN  = 16'h98;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_FOUND  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Digest words in MD5 output order, A in the most significant position
  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
    logic [WORD_W-1:0] d;
  } digest_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/md5_digest_eq.sv
// Registered per-word comparison of two 128-bit MD5 digests.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   en           : register enable; eq holds while low
//   lhs, rhs     : digests to compare, word A in [127:96]
//   eq           : registered equality bits, eq[3]=A ... eq[0]=D
module md5_digest_eq
  import md5_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic [DIGEST_W-1:0] lhs,
  input  logic [DIGEST_W-1:0] rhs,
  output logic [3:0]          eq
);

  digest_t l;
  digest_t r;

  assign l = digest_t'(lhs);
  assign r = digest_t'(rhs);

  // One equality bit per digest word
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      eq <= 4'd0;
    end else if (en) begin
      eq <= {l.a == r.a, l.b == r.b, l.c == r.c, l.d == r.d};
    end
  end

endmodule

// File: rtl/md5_match.sv
// Search-result stage: compares each digest from md5core against an armed
// target, counts evaluated results, captures the message of the first match,
// or reports exhaustion after max_count results.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   en                  : global enable; all state holds while low
//   start               : latch target/limit, clear results, (re)arm search
//   target_hash         : expected digest, [127:96]=A .. [31:0]=D
//   max_count           : results to evaluate before DONE, 0 = unlimited
//   a_in..d_in          : digest words from md5core
//   m_in                : padded block from md5core, message in the top bits
//   valid_in            : digest/block valid
//   busy / match / done : state is SEARCH / FOUND / DONE
//   match_mesg          : captured candidate message
//   hash_count          : results evaluated since the last start
module md5_match
  import md5_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                start,
  input  logic [DIGEST_W-1:0] target_hash,
  input  logic [CNT_W-1:0]    max_count,
  input  logic [WORD_W-1:0]   a_in,
  input  logic [WORD_W-1:0]   b_in,
  input  logic [WORD_W-1:0]   c_in,
  input  logic [WORD_W-1:0]   d_in,
  input  logic [BLOCK_W-1:0]  m_in,
  input  logic                valid_in,
  output logic                busy,
  output logic                match,
  output logic                done,
  output logic [MSG_BITS-1:0] match_mesg,
  output logic [CNT_W-1:0]    hash_count
);

  state_t              state;
  state_t              state_next;
  logic [DIGEST_W-1:0] target_q;
  logic [CNT_W-1:0]    max_q;
  logic                v1;
  logic [MSG_BITS-1:0] msg_s1;
  logic [3:0]          eq_s1;
  logic                eval;
  logic                hit;
  logic                limit_hit;
  logic [CNT_W-1:0]    cnt_inc;
  logic                unused_ok;

  // Block padding and length field travel with the message but are not compared
  assign unused_ok = ^{m_in[BLOCK_W-MSG_BITS-1:0], PAD_BYTE, MSG_LEN};

  // Stage 1 equality bits against the latched target
  md5_digest_eq u_digest_eq (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .lhs     ({a_in, b_in, c_in, d_in}),
    .rhs     (target_q),
    .eq      (eq_s1)
  );

  // Stage 2 evaluation and next-state selection
  always_comb begin
    state_next = state;
    eval       = v1 && (state == ST_SEARCH);
    hit        = eval && (&eq_s1);
    cnt_inc    = sat_inc(hash_count);
    limit_hit  = eval && (max_q != CNT_W'(0)) && (cnt_inc == max_q);

    case (state)
      ST_IDLE:   if (start) state_next = ST_SEARCH;
      ST_SEARCH: begin
        if (start)          state_next = ST_SEARCH;
        else if (hit)       state_next = ST_FOUND;   // a match beats the limit
        else if (limit_hit) state_next = ST_DONE;
      end
      ST_FOUND:  if (start) state_next = ST_SEARCH;
      ST_DONE:   if (start) state_next = ST_SEARCH;
      default:   state_next = ST_IDLE;
    endcase

    if (!en) state_next = state;
  end

  // State register and state-decoded status outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      match <= 1'b0;
      done  <= 1'b0;
    end else if (en) begin
      state <= state_next;
      busy  <= (state_next == ST_SEARCH);
      match <= (state_next == ST_FOUND);
      done  <= (state_next == ST_DONE);
    end
  end

  // Datapath: arm/flush on start, otherwise advance stage 1 and commit stage 2
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      target_q   <= '0;
      max_q      <= '0;
      v1         <= 1'b0;
      msg_s1     <= '0;
      hash_count <= '0;
      match_mesg <= '0;
    end else if (en) begin
      msg_s1 <= m_in[BLOCK_W-1 -: MSG_BITS];
      if (start) begin
        target_q   <= target_hash;
        max_q      <= max_count;
        v1         <= 1'b0;
        hash_count <= '0;
        match_mesg <= '0;
      end else begin
        v1 <= valid_in;
        if (eval) hash_count <= cnt_inc;
        if (hit)  match_mesg <= msg_s1;
      end
    end
  end

endmodule

// File: tb/tb_md5_match.sv
// Self-checking bench for md5_match: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_md5_match;
  import md5_pkg::*;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                en;
  logic                start;
  logic [127:0]        target_hash;
  logic [31:0]         max_count;
  logic [31:0]         a_in, b_in, c_in, d_in;
  logic [511:0]        m_in;
  logic                valid_in;
  logic                busy, match, done;
  logic [151:0]        match_mesg;
  logic [31:0]         hash_count;

  always #5 clk = ~clk;

  md5_match dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .start       (start),
    .target_hash (target_hash),
    .max_count   (max_count),
    .a_in        (a_in),
    .b_in        (b_in),
    .c_in        (c_in),
    .d_in        (d_in),
    .m_in        (m_in),
    .valid_in    (valid_in),
    .busy        (busy),
    .match       (match),
    .done        (done),
    .match_mesg  (match_mesg),
    .hash_count  (hash_count)
  );

  localparam logic [127:0] DG_FOX   = 128'ha2004f37_730b9445_670a738f_a0fc9ee5;
  localparam logic [127:0] DG_HELLO = 128'h1111aaaa_2222bbbb_3333cccc_4444dddd;
  localparam logic [127:0] DG_TEST  = 128'h5a5a0101_c3c30202_96960303_0f0f0404;
  localparam logic [151:0] MS_FOX   = 152'h54686520_71756963_6b206272_6f776e20_666f78;
  localparam logic [151:0] MS_HELLO = 152'h48656c6c_6f20576f_726c6420_31323334_353637;
  localparam logic [151:0] MS_TEST  = 152'h54686973_20697320_61207465_73742e20_313233;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [151:0] got, input logic [151:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: search mode, counters and the one result awaiting evaluation
  typedef enum int {M_IDLE, M_SEARCH, M_FOUND, M_DONE} mode_t;
  mode_t        m_mode;
  logic [31:0]  m_cnt, m_max;
  logic [127:0] m_tgt;
  logic [151:0] m_mesg;
  bit           p_v;
  logic [127:0] p_dig;
  logic [151:0] p_msg;

  task automatic model_edge(input bit st, input bit vi, input logic [127:0] dig,
                            input logic [151:0] msg);
    if (!reset_n) begin
      m_mode = M_IDLE; m_cnt = 0; m_max = 0; m_tgt = 0; m_mesg = 0; p_v = 0;
    end else if (en) begin
      if (st) begin
        m_mode = M_SEARCH; m_cnt = 0; m_mesg = 0; p_v = 0;
        m_tgt = target_hash; m_max = max_count;
      end else begin
        if (p_v && m_mode == M_SEARCH) begin
          if (m_cnt != 32'hffff_ffff) m_cnt = m_cnt + 1;
          if (p_dig == m_tgt) begin
            m_mode = M_FOUND; m_mesg = p_msg;
          end else if (m_max != 0 && m_cnt == m_max) begin
            m_mode = M_DONE;
          end
        end
        p_v = vi; p_dig = dig; p_msg = msg;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare #1 later
  task automatic step(input bit st, input bit vi, input logic [127:0] dig,
                      input logic [151:0] msg);
    start    = st;
    valid_in = vi;
    {a_in, b_in, c_in, d_in} = dig;
    m_in = {msg, 8'h80, 288'd0, 64'h9800_0000_0000_0000};
    @(posedge clk);
    #1;
    model_edge(st, vi, dig, msg);
    check("busy",       152'(busy),       152'(m_mode == M_SEARCH));
    check("match",      152'(match),      152'(m_mode == M_FOUND));
    check("done",       152'(done),       152'(m_mode == M_DONE));
    check("hash_count", 152'(hash_count), 152'(m_cnt));
    check("match_mesg", match_mesg,       m_mesg);
    start    = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 128'd0, 152'd0);
  endtask

  task automatic arm(input logic [127:0] tgt, input logic [31:0] lim);
    target_hash = tgt;
    max_count   = lim;
    step(1'b1, 1'b0, 128'd0, 152'd0);
    target_hash = $urandom;  // later changes must be ignored
    max_count   = $urandom;
  endtask

  function automatic logic [151:0] rnd_msg();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[151:0];
  endfunction

  function automatic logic [127:0] rnd_dig();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] pool [4];

  initial begin
    reset_n = 1'b0; en = 1'b1; start = 1'b0; valid_in = 1'b0;
    target_hash = '0; max_count = '0; {a_in, b_in, c_in, d_in} = '0; m_in = '0;
    m_mode = M_IDLE; m_cnt = 0; m_max = 0; m_tgt = 0; m_mesg = 0; p_v = 0;
    p_dig = 0; p_msg = 0;

    // Reset, with start asserted to show reset wins
    step(1'b1, 1'b1, DG_FOX, MS_FOX);
    step(1'b0, 1'b0, 128'd0, 152'd0);
    check("rst_busy", 152'(busy), 152'd0);
    check("rst_cnt",  152'(hash_count), 152'd0);
    reset_n = 1'b1;
    idle(1);

    // Single matching result, visible two cycles after it is presented
    arm(DG_FOX, 32'd0);
    check("arm_busy", 152'(busy), 152'd1);
    step(1'b0, 1'b1, DG_FOX, MS_FOX);
    check("fox_early", 152'(match), 152'd0);
    idle(1);
    check("fox_match", 152'(match), 152'd1);
    check("fox_mesg",  match_mesg, 152'h54686520_71756963_6b206272_6f776e20_666f78);
    check("fox_cnt",   152'(hash_count), 152'd1);

    // Match on the third of three back-to-back results
    arm(DG_TEST, 32'd0);
    step(1'b0, 1'b1, DG_FOX, MS_FOX);
    step(1'b0, 1'b1, DG_HELLO, MS_HELLO);
    step(1'b0, 1'b1, DG_TEST, MS_TEST);
    idle(2);
    check("b2b_match", 152'(match), 152'd1);
    check("b2b_cnt",   152'(hash_count), 152'd3);
    check("b2b_mesg",  match_mesg, MS_TEST);

    // Limit reached without a match; later results ignored
    arm(DG_TEST, 32'd2);
    step(1'b0, 1'b1, DG_FOX, MS_FOX);
    step(1'b0, 1'b1, DG_HELLO, MS_HELLO);
    idle(1);
    check("lim_done", 152'(done), 152'd1);
    check("lim_busy", 152'(busy), 152'd0);
    check("lim_cnt",  152'(hash_count), 152'd2);
    step(1'b0, 1'b1, DG_TEST, MS_TEST);
    idle(2);
    check("lim_hold", 152'(hash_count), 152'd2);

    // Match on the evaluation that also reaches the limit
    arm(DG_HELLO, 32'd2);
    step(1'b0, 1'b1, DG_FOX, MS_FOX);
    step(1'b0, 1'b1, DG_HELLO, MS_HELLO);
    idle(1);
    check("sim_match", 152'(match), 152'd1);
    check("sim_done",  152'(done), 152'd0);

    // Restart after FOUND clears the result; restart flushes a result in stage 1
    arm(DG_FOX, 32'd0);
    check("rst_mesg", match_mesg, 152'd0);
    step(1'b0, 1'b1, DG_FOX, MS_FOX);
    arm(DG_FOX, 32'd0);
    idle(2);
    check("flush_cnt",   152'(hash_count), 152'd0);
    check("flush_match", 152'(match), 152'd0);

    // Enable low for three cycles stretches the latency by three
    step(1'b0, 1'b1, DG_FOX, MS_FOX);
    en = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rnd_dig(), rnd_msg());
    check("en_hold", 152'(match), 152'd0);
    en = 1'b1;
    idle(1);
    check("en_match", 152'(match), 152'd1);
    check("en_cnt",   152'(hash_count), 152'd1);

    // Reset in the middle of a search
    arm(DG_TEST, 32'd0);
    step(1'b0, 1'b1, DG_FOX, MS_FOX);
    step(1'b0, 1'b1, DG_TEST, MS_TEST);
    reset_n = 1'b0;
    step(1'b0, 1'b1, DG_TEST, MS_TEST);
    check("mid_rst_busy", 152'(busy), 152'd0);
    check("mid_rst_cnt",  152'(hash_count), 152'd0);
    reset_n = 1'b1;
    idle(2);

    // Random traffic from a small digest pool so matches occur
    pool[0] = DG_FOX; pool[1] = DG_HELLO; pool[2] = DG_TEST; pool[3] = rnd_dig();
    arm(pool[$urandom_range(0, 3)], 32'($urandom_range(0, 6)));
    for (int i = 0; i < 600; i++) begin
      bit st;
      en      = ($urandom_range(0, 9) != 0);
      reset_n = ($urandom_range(0, 249) != 0);
      st      = en && ($urandom_range(0, 24) == 0);
      if (st) begin
        target_hash = pool[$urandom_range(0, 3)];
        max_count   = 32'($urandom_range(0, 6));
      end
      step(st, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? rnd_dig() : pool[$urandom_range(0, 3)],
           rnd_msg());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
